// File: rtl/display_cmd_buffer.sv
// First-word-fall-through command FIFO feeding display_controller, with flush,
// sticky overflow and fill-level status. Define DISP_BUF_COALESCE_EN to merge repeated ops.
module display_cmd_buffer #(
  parameter int DEPTH  = 8,
  parameter int OP_W   = 3,
  parameter int DATA_W = 26,
  parameter int HWM    = 6
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wr_en,
  input  logic [OP_W-1:0]            i_wr_op,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic                       i_flush,
  input  logic                       i_clr_overflow,
  input  logic                       i_buf_rd_en,
  output logic                       o_buf_has_entry,
  output logic [OP_W-1:0]            o_display_op,
  output logic [DATA_W-1:0]          o_display_data,
  output logic                       o_full,
  output logic                       o_almost_full,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = OP_W + DATA_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] HWM_C   = CW'(HWM);

  logic [EW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [CW-1:0]  count_reg;
  logic           overflow_reg;

  logic           pop_acc;
  logic           push_acc;
  logic           merge;
  logic           drop;
  logic           mem_we;
  logic [AW-1:0]  mem_waddr;
  logic [AW-1:0]  last_ptr;
  logic [EW-1:0]  head_entry;

  assign last_ptr = wr_ptr_reg - 1'b1;
  assign pop_acc  = i_buf_rd_en && (count_reg != '0);

`ifdef DISP_BUF_COALESCE_EN
  logic [OP_W-1:0] last_op;
  assign last_op = mem[last_ptr][EW-1:DATA_W];
  // count > 1 guarantees the most recent entry is not the head being presented.
  assign merge = i_wr_en && !pop_acc && (count_reg > CW'(1)) && (last_op == i_wr_op);
`else
  assign merge = 1'b0;
`endif

  assign push_acc  = i_wr_en && !merge && ((count_reg < DEPTH_C) || pop_acc);
  assign drop      = i_wr_en && !merge && !push_acc;
  assign mem_we    = !i_rst && !i_flush && (push_acc || merge);
  assign mem_waddr = merge ? last_ptr : wr_ptr_reg;

  // Storage carries no reset so it maps onto plain distributed RAM.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= {i_wr_op, i_wr_data};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (i_flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_acc) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push_acc && !pop_acc) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop_acc && !push_acc) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  // A drop in the same cycle as a clear leaves the flag set; flushed pushes never count as drops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      overflow_reg <= 1'b0;
    end else if (drop && !i_flush) begin
      overflow_reg <= 1'b1;
    end else if (i_clr_overflow) begin
      overflow_reg <= 1'b0;
    end
  end

  assign head_entry      = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
  assign o_display_op    = head_entry[EW-1:DATA_W];
  assign o_display_data  = head_entry[DATA_W-1:0];
  assign o_buf_has_entry = (count_reg != '0);
  assign o_full          = (count_reg == DEPTH_C);
  assign o_almost_full   = (count_reg >= HWM_C);
  assign o_count         = count_reg;
  assign o_overflow      = overflow_reg;

endmodule

// File: tb/tb_display_cmd_buffer.sv
// Directed self-checking bench for display_cmd_buffer (default parameters).
module tb_display_cmd_buffer;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_op;
  logic [25:0] wr_data;
  logic        flush;
  logic        clr_ovf;
  logic        rd_en;
  logic        has_entry;
  logic [2:0]  disp_op;
  logic [25:0] disp_data;
  logic        full;
  logic        almost_full;
  logic [3:0]  count;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  display_cmd_buffer dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_wr_en         (wr_en),
    .i_wr_op         (wr_op),
    .i_wr_data       (wr_data),
    .i_flush         (flush),
    .i_clr_overflow  (clr_ovf),
    .i_buf_rd_en     (rd_en),
    .o_buf_has_entry (has_entry),
    .o_display_op    (disp_op),
    .o_display_data  (disp_data),
    .o_full          (full),
    .o_almost_full   (almost_full),
    .o_count         (count),
    .o_overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // One clock cycle with the given controls; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic we, input logic [2:0] op, input logic [25:0] d,
                     input logic re, input logic fl, input logic clr);
    wr_en = we; wr_op = op; wr_data = d; rd_en = re; flush = fl; clr_ovf = clr;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic push(input logic [2:0] op, input logic [25:0] d);
    cyc(1'b1, op, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, 3'd0, 26'd0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_op = '0; wr_data = '0;
    flush = 1'b0; clr_ovf = 1'b0; rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_has", 32'(has_entry), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_afull", 32'(almost_full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_data", 32'(disp_data), 32'd0);
    check("rst_op", 32'(disp_op), 32'd0);
    rst = 1'b0;

    // Single push: visible one cycle after the write edge.
    push(3'd1, 26'h0012345);
    check("p1_has", 32'(has_entry), 32'd1);
    check("p1_data", 32'(disp_data), 32'h0012345);
    check("p1_op", 32'(disp_op), 32'd1);
    check("p1_count", 32'(count), 32'd1);
    pop();
    check("p1_pop_has", 32'(has_entry), 32'd0);
    check("p1_pop_count", 32'(count), 32'd0);

    // Fill to DEPTH, watching the almost-full threshold.
    for (int i = 0; i < 8; i++) begin
      push(3'(i), 26'(i));
      check($sformatf("fill_count%0d", i), 32'(count), 32'(i + 1));
      check($sformatf("fill_afull%0d", i), 32'(almost_full), 32'((i + 1) >= 6));
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_head", 32'(disp_data), 32'd0);
    push(3'd0, 26'd99);
    check("drop_ovf", 32'(overflow), 32'd1);
    check("drop_count", 32'(count), 32'd8);
    cyc(1'b0, 3'd0, 26'd0, 1'b0, 1'b0, 1'b1);
    check("clr_ovf", 32'(overflow), 32'd0);

    // Full with concurrent push and pop: head 0 leaves, new entry takes the freed slot.
    cyc(1'b1, 3'd5, 26'h3FFFFFF, 1'b1, 1'b0, 1'b0);
    check("fullrw_count", 32'(count), 32'd8);
    check("fullrw_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain_head%0d", i), 32'(disp_data), (i == 8) ? 32'h3FFFFFF : 32'(i));
      pop();
    end
    check("drain_count", 32'(count), 32'd0);

    // Pointer wrap with steady-state push+pop; alternating ops keep coalescing out of play.
    push(3'd1, 26'd100);
    for (int k = 1; k < 20; k++) begin
      cyc(1'b1, 3'(1 + (k % 2)), 26'(100 + k), 1'b1, 1'b0, 1'b0);
      check($sformatf("wrap_head%0d", k), 32'(disp_data), 32'(100 + k));
      check($sformatf("wrap_count%0d", k), 32'(count), 32'd1);
    end
    pop();
    check("wrap_empty", 32'(count), 32'd0);
    pop();
    check("empty_pop_count", 32'(count), 32'd0);
    check("empty_pop_has", 32'(has_entry), 32'd0);

    // Flush beats a same-cycle push and does not raise overflow.
    for (int i = 0; i < 5; i++) push(3'(i + 1), 26'(200 + i));
    check("pre_flush_count", 32'(count), 32'd5);
    cyc(1'b1, 3'd7, 26'd7, 1'b0, 1'b1, 1'b0);
    check("flush_count", 32'(count), 32'd0);
    check("flush_has", 32'(has_entry), 32'd0);
    check("flush_ovf", 32'(overflow), 32'd0);

    // Drop together with clear: set wins; flush keeps the sticky flag.
    for (int i = 0; i < 8; i++) push(3'(i), 26'(300 + i));
    cyc(1'b1, 3'd0, 26'd1, 1'b0, 1'b0, 1'b1);
    check("drop_clr_ovf", 32'(overflow), 32'd1);
    check("drop_clr_head", 32'(disp_data), 32'd300);
    cyc(1'b0, 3'd0, 26'd0, 1'b0, 1'b1, 1'b0);
    check("flush_keep_ovf", 32'(overflow), 32'd1);
    check("flush_keep_count", 32'(count), 32'd0);
    cyc(1'b0, 3'd0, 26'd0, 1'b0, 1'b0, 1'b1);
    check("clr2_ovf", 32'(overflow), 32'd0);

    // Coalescing stimulus: result depends on the build option.
    push(3'd2, 26'h00000A);
    push(3'd3, 26'h00000B);
    push(3'd3, 26'h00000C);
`ifdef DISP_BUF_COALESCE_EN
    check("coal_count", 32'(count), 32'd2);
    check("coal_pop0", 32'(disp_data), 32'h00000A);
    pop();
    check("coal_pop1", 32'(disp_data), 32'h00000C);
    pop();
`else
    check("coal_count", 32'(count), 32'd3);
    check("coal_pop0", 32'(disp_data), 32'h00000A);
    pop();
    check("coal_pop1", 32'(disp_data), 32'h00000B);
    pop();
    check("coal_pop2", 32'(disp_data), 32'h00000C);
    pop();
`endif
    check("coal_empty", 32'(count), 32'd0);

    // Reset mid-operation drops pending entries.
    push(3'd4, 26'h1234);
    push(3'd5, 26'h5678);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_has", 32'(has_entry), 32'd0);
    check("midrst_data", 32'(disp_data), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
